truth_table_scan: RTL and testbench

TRUTH_TABLE_SCAN -- requirements
Module: truth_table_scan

---
 rtl/truth_table_scan.sv | 140 ++++++++++++++
 tb/tb_truth_table_scan.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scan.sv
// truth_table_scan: exhaustive truth-table comparator for two implementations.
// Walks every N-bit input vector, gives the external logic a full cycle to
// settle, then captures both results. The first vector on which they
// disagree is latched.
// All outputs come straight from registers, so a_in/b_in never reach an
// output combinationally.
module truth_table_scan #(
  parameter int N = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic [N-1:0]        x_out,
  input  logic                a_in,
  input  logic                b_in,
  output logic                busy,
  output logic                done,
  output logic [(1<<N)-1:0]   table_a,
  output logic [(1<<N)-1:0]   table_b,
  output logic                mismatch,
  output logic [N-1:0]        mismatch_idx
);

  localparam int            V        = 1 << N;
  localparam logic [N-1:0]  VEC_LAST = N'(V - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         state_q;
  logic [N-1:0]   vec_q;
  logic [N-1:0]   x_out_q;
  logic           busy_q;
  logic           done_q;
  logic [V-1:0]   table_a_q;
  logic [V-1:0]   table_b_q;
  logic           mismatch_q;
  logic [N-1:0]   mismatch_idx_q;

  logic [N-1:0]   vec_d;
  logic           diff_d;

  // Next vector index and the per-vector disagreement flag.
  always_comb begin
    vec_d  = vec_q + N'(1);
    diff_d = (a_in != b_in);
  end

  // Scan FSM; every output register is loaded with the value for the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      vec_q          <= '0;
      x_out_q        <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      table_a_q      <= '0;
      table_b_q      <= '0;
      mismatch_q     <= 1'b0;
      mismatch_idx_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          x_out_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start) begin
            // A new scan wipes the previous results at the start edge.
            state_q        <= S_DRIVE;
            vec_q          <= '0;
            busy_q         <= 1'b1;
            table_a_q      <= '0;
            table_b_q      <= '0;
            mismatch_q     <= 1'b0;
            mismatch_idx_q <= '0;
          end
        end

        S_DRIVE: begin
          // Vector has been on x_out for one full cycle; sample on the next edge.
          state_q <= S_SAMPLE;
          x_out_q <= vec_q;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end

        S_SAMPLE: begin
          table_a_q[vec_q] <= a_in;
          table_b_q[vec_q] <= b_in;
          // Only the first disagreement is recorded.
          if (diff_d && !mismatch_q) begin
            mismatch_q     <= 1'b1;
            mismatch_idx_q <= vec_q;
          end
          if (vec_q == VEC_LAST) begin
            // vec is left at its last value rather than wrapping.
            state_q <= S_DONE;
            x_out_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_DRIVE;
            vec_q   <= vec_d;
            x_out_q <= vec_d;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end

        S_DONE: begin
          // Single-cycle done pulse; start is not looked at here.
          state_q <= S_IDLE;
          x_out_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          x_out_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x_out        = x_out_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_a      = table_a_q;
  assign table_b      = table_b_q;
  assign mismatch     = mismatch_q;
  assign mismatch_idx = mismatch_idx_q;

endmodule

// File: tb/tb_truth_table_scan.sv
// Bench for truth_table_scan: N=2 and N=3 instances driven by directed and
// random combinational functions, checked against a table-level model.
module tb_truth_table_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start2, start3;
  logic a2, b2, a3, b3;
  int   mode;
  int   sel;
  logic [3:0] rA2, rB2;
  logic [7:0] rA3, rB3;

  logic [1:0] x2, mi2;
  logic       bz2, dn2, mm2;
  logic [3:0] ta2, tb2;
  logic [2:0] x3, mi3;
  logic       bz3, dn3, mm3;
  logic [7:0] ta3, tb3;

  int total = 0;
  int bad   = 0;

  truth_table_scan #(.N(2)) u2 (
    .clock(clk), .reset(rst), .start(start2), .x_out(x2), .a_in(a2), .b_in(b2),
    .busy(bz2), .done(dn2), .table_a(ta2), .table_b(tb2),
    .mismatch(mm2), .mismatch_idx(mi2)
  );

  truth_table_scan #(.N(3)) u3 (
    .clock(clk), .reset(rst), .start(start3), .x_out(x3), .a_in(a3), .b_in(b3),
    .busy(bz3), .done(dn3), .table_a(ta3), .table_b(tb3),
    .mismatch(mm3), .mismatch_idx(mi3)
  );

  // Functions under comparison, evaluated from the scanner's test vector.
  always_comb begin
    case (mode)
      0: begin
        a2 = ~(x2[1] & ~x2[0]);
        b2 = ~(~x2[1] & x2[0]);
      end
      1: begin
        a2 = ~(x2[1] & ~(x2[0] & x2[0]));
        b2 = ~(x2[1] & ~(x2[0] & x2[0]));
      end
      default: begin
        a2 = rA2[x2];
        b2 = rB2[x2];
      end
    endcase
    a3 = (mode == 2) ? rA3[x3] : x3[0];
    b3 = (mode == 2) ? rB3[x3] : x3[1];
  end

  // Observed outputs of whichever instance is being scanned.
  logic [2:0] xo, mi;
  logic       bz, dn, mm;
  logic [7:0] ta, tbo;
  always_comb begin
    xo = {1'b0, x2}; mi = {1'b0, mi2}; bz = bz2; dn = dn2; mm = mm2;
    ta = {4'b0, ta2}; tbo = {4'b0, tb2};
    if (sel == 3) begin
      xo = x3; mi = mi3; bz = bz3; dn = dn3; mm = mm3; ta = ta3; tbo = tb3;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full scan. Cycle c counts from the start edge; vector k occupies
  // cycles 2k+1 and 2k+2, and done occupies cycle 2^(n+1)+1.
  task automatic scan(input int n, input bit hold, input logic [7:0] eA,
                      input logic [7:0] eB, input logic eM, input logic [2:0] eI);
    int L;
    L   = (1 << (n + 1)) + 1;
    sel = n;
    @(negedge clk);
    chk("idle_busy", bz, 0);
    chk("idle_done", dn, 0);
    chk("idle_x", xo, 0);
    if (n == 2) start2 = 1'b1; else start3 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= L; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (!hold) begin start2 = 1'b0; start3 = 1'b0; end
        chk("clr_table_a", ta, 0);
        chk("clr_table_b", tbo, 0);
        chk("clr_mismatch", mm, 0);
        chk("clr_idx", mi, 0);
      end
      if (c < L) begin
        chk("scan_x", xo, (c - 1) / 2);
        chk("scan_busy", bz, 1);
        chk("scan_done", dn, 0);
      end else begin
        chk("done_pulse", dn, 1);
        chk("done_busy", bz, 0);
        chk("done_x", xo, 0);
        chk("table_a", ta, eA);
        chk("table_b", tbo, eB);
        chk("mismatch", mm, eM);
        chk("mismatch_idx", mi, eI);
      end
    end
  endtask

  // Reference: expected flags from two whole truth tables.
  function automatic logic [2:0] first_diff(input logic [7:0] d);
    for (int i = 0; i < 8; i++)
      if (d[i]) return 3'(i);
    return 3'd0;
  endfunction

  initial begin
    logic [7:0] d;
    rst = 1'b1; start2 = 1'b0; start3 = 1'b0; mode = 0; sel = 2;
    rA2 = '0; rB2 = '0; rA3 = '0; rB3 = '0;
    #12;
    chk("rst_x", xo, 0);
    chk("rst_busy", bz, 0);
    chk("rst_done", dn, 0);
    chk("rst_table_a", ta, 0);
    chk("rst_table_b", tbo, 0);
    chk("rst_mismatch", mm, 0);
    chk("rst_idx", mi, 0);
    @(negedge clk);
    rst = 1'b0;

    // Differing functions, then equivalent NAND forms (mismatch must clear).
    mode = 0;
    scan(2, 0, 8'h0B, 8'h0D, 1'b1, 3'd1);
    mode = 1;
    scan(2, 0, 8'h0B, 8'h0B, 1'b0, 3'd0);

    // Start held high: back-to-back scans with one idle cycle between.
    mode = 0;
    scan(2, 1, 8'h0B, 8'h0D, 1'b1, 3'd1);
    scan(2, 1, 8'h0B, 8'h0D, 1'b1, 3'd1);
    scan(2, 0, 8'h0B, 8'h0D, 1'b1, 3'd1);

    // Reset during SAMPLE of vector 2.
    sel = 2;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_x", xo, 2);
    chk("pre_rst_busy", bz, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_x", xo, 0);
    chk("arst_busy", bz, 0);
    chk("arst_done", dn, 0);
    chk("arst_table_a", ta, 0);
    chk("arst_table_b", tbo, 0);
    chk("arst_mismatch", mm, 0);
    chk("arst_idx", mi, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_done", dn, 0);
    end
    rst = 1'b0;
    scan(2, 0, 8'h0B, 8'h0D, 1'b1, 3'd1);

    // N=3 directed.
    scan(3, 0, 8'hAA, 8'hCC, 1'b1, 3'd1);

    // Random truth tables against the table-level model.
    mode = 2;
    for (int it = 0; it < 6; it++) begin
      rA2 = 4'($urandom);
      rB2 = (it == 0) ? rA2 : 4'($urandom);
      d   = {4'b0, rA2 ^ rB2};
      scan(2, 0, {4'b0, rA2}, {4'b0, rB2}, |d, first_diff(d));
    end
    for (int it = 0; it < 4; it++) begin
      rA3 = 8'($urandom);
      rB3 = (it == 0) ? rA3 : 8'($urandom);
      d   = rA3 ^ rB3;
      scan(3, 0, rA3, rB3, |d, first_diff(d));
    end

    @(negedge clk);
    @(negedge clk);
    chk("final_idle_busy", bz, 0);
    chk("final_idle_done", dn, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
